// File: rtl/dec_pkg.sv
// Shared definitions for the decoder correction path: codeword-width encodings,
// the width lookup and the error-classification enum.
package dec_pkg;

    localparam logic [1:0] CW_8  = 2'b00;
    localparam logic [1:0] CW_16 = 2'b01;
    localparam logic [1:0] CW_32 = 2'b10;

    typedef enum logic [1:0] {
        NO_ERR     = 2'd0,
        SINGLE_ERR = 2'd1,
        MULTI_ERR  = 2'd2
    } err_e;

    // Bit 1 wins over bit 0, so 2'b11 also selects the 32-bit width.
    function automatic logic [5:0] cw_width(input logic [1:0] enc);
        logic [5:0] w;
        case (enc)
            CW_8:    w = 6'd8;
            CW_16:   w = 6'd16;
            default: w = 6'd32;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/dec_err_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module dec_err_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/dec_correct_stage.sv
// Two-stage single-error correction stage with valid/ready on both sides.
// Define DEC_ERR_STATS_EN to build the saturating single/multi-error counters.
module dec_correct_stage
    import dec_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] codeword,
    input  logic [5:0]        s,
    input  logic [1:0]        codeword_width,
    input  logic              isCol,
    input  logic [4:0]        whatCol,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic [1:0]        num_of_errors,
    output logic [CNT_W-1:0]  single_cnt,
    output logic [CNT_W-1:0]  double_cnt,
    input  logic              stats_clr
);

    function automatic logic [DATA_W-1:0] width_mask(input logic [5:0] w);
        logic [DATA_W-1:0] m;
        for (int i = 0; i < DATA_W; i++) begin
            m[i] = (i < int'(w));
        end
        return m;
    endfunction

    function automatic logic [DATA_W-1:0] flip_bit(input logic [DATA_W-1:0] d,
                                                   input logic [4:0]        idx);
        logic [DATA_W-1:0] r;
        r = d;
        for (int i = 0; i < DATA_W; i++) begin
            if (i == int'(idx)) begin
                r[i] = ~d[i];
            end
        end
        return r;
    endfunction

    // A located column outside the active width cannot be a real single error.
    function automatic err_e classify(input logic [5:0] syn,
                                      input logic       col_hit,
                                      input logic [4:0] col_idx,
                                      input logic [5:0] w);
        err_e e;
        if (syn == 6'd0) begin
            e = NO_ERR;
        end else if (col_hit && ({1'b0, col_idx} < w)) begin
            e = SINGLE_ERR;
        end else begin
            e = MULTI_ERR;
        end
        return e;
    endfunction

    logic              vld_p1_q, vld_p1_d;
    logic [DATA_W-1:0] data_p1_q, data_p1_d;
    logic [5:0]        s_p1_q, s_p1_d;
    logic              iscol_p1_q, iscol_p1_d;
    logic [4:0]        whatcol_p1_q, whatcol_p1_d;
    logic [5:0]        width_p1_q, width_p1_d;

    logic              vld_p2_q, vld_p2_d;
    logic [DATA_W-1:0] data_p2_q, data_p2_d;
    err_e              err_p2_q, err_p2_d;

    logic              ld_p2;
    logic              acc;
    err_e              err_p1;

    always_comb begin
        ld_p2    = !vld_p2_q || out_ready;
        in_ready = !vld_p1_q || ld_p2;
        acc      = in_valid && in_ready;
    end

    // Stage 1: capture the word masked to its own active width.
    always_comb begin
        vld_p1_d     = in_ready ? acc : vld_p1_q;
        data_p1_d    = data_p1_q;
        s_p1_d       = s_p1_q;
        iscol_p1_d   = iscol_p1_q;
        whatcol_p1_d = whatcol_p1_q;
        width_p1_d   = width_p1_q;
        if (acc) begin
            width_p1_d   = cw_width(codeword_width);
            data_p1_d    = codeword & width_mask(width_p1_d);
            s_p1_d       = s;
            iscol_p1_d   = isCol;
            whatcol_p1_d = whatCol;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1_q <= 1'b0;
        end else begin
            vld_p1_q <= vld_p1_d;
        end
    end

    always_ff @(posedge clk) begin
        data_p1_q    <= data_p1_d;
        s_p1_q       <= s_p1_d;
        iscol_p1_q   <= iscol_p1_d;
        whatcol_p1_q <= whatcol_p1_d;
        width_p1_q   <= width_p1_d;
    end

    // Stage 2: classify and correct straight into the output register.
    always_comb begin
        err_p1    = classify(s_p1_q, iscol_p1_q, whatcol_p1_q, width_p1_q);
        vld_p2_d  = vld_p2_q;
        data_p2_d = data_p2_q;
        err_p2_d  = err_p2_q;
        if (ld_p2) begin
            vld_p2_d = vld_p1_q;
            if (vld_p1_q) begin
                err_p2_d  = err_p1;
                data_p2_d = (err_p1 == SINGLE_ERR) ? flip_bit(data_p1_q, whatcol_p1_q)
                                                   : data_p1_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p2_q  <= 1'b0;
            data_p2_q <= '0;
            err_p2_q  <= NO_ERR;
        end else begin
            vld_p2_q  <= vld_p2_d;
            data_p2_q <= data_p2_d;
            err_p2_q  <= err_p2_d;
        end
    end

    assign out_valid     = vld_p2_q;
    assign data_out      = data_p2_q;
    assign num_of_errors = err_p2_q;

`ifdef DEC_ERR_STATS_EN
    logic out_fire;
    logic single_inc;
    logic double_inc;

    always_comb begin
        out_fire   = vld_p2_q && out_ready;
        single_inc = out_fire && (err_p2_q == SINGLE_ERR);
        double_inc = out_fire && (err_p2_q == MULTI_ERR);
    end

    dec_err_counter #(
        .CNT_W(CNT_W)
    ) u_single_cnt (
        .clk (clk),
        .rst (rst),
        .clr (stats_clr),
        .inc (single_inc),
        .cnt (single_cnt)
    );

    dec_err_counter #(
        .CNT_W(CNT_W)
    ) u_double_cnt (
        .clk (clk),
        .rst (rst),
        .clr (stats_clr),
        .inc (double_inc),
        .cnt (double_cnt)
    );
`else
    logic unused_stats_clr;

    assign unused_stats_clr = stats_clr;
    assign single_cnt       = '0;
    assign double_cnt       = '0;
`endif

endmodule

// File: tb/tb_dec_correct_stage.sv
// Bench for dec_correct_stage: scoreboard model plus directed vectors.
module tb_dec_correct_stage;
    import dec_pkg::*;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] codeword;
    logic [5:0]        s;
    logic [1:0]        codeword_width;
    logic              isCol;
    logic [4:0]        whatCol;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] data_out;
    logic [1:0]        num_of_errors;
    logic [CNT_W-1:0]  single_cnt;
    logic [CNT_W-1:0]  double_cnt;
    logic              stats_clr;

    dec_correct_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .codeword       (codeword),
        .s              (s),
        .codeword_width (codeword_width),
        .isCol          (isCol),
        .whatCol        (whatCol),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .data_out       (data_out),
        .num_of_errors  (num_of_errors),
        .single_cnt     (single_cnt),
        .double_cnt     (double_cnt),
        .stats_clr      (stats_clr)
    );

    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_pass  = 0;
    int          n_waits = 0;
    logic        chk_en  = 1'b0;
    logic [33:0] expq[$];
    logic        prev_stall = 1'b0;
    logic [33:0] prev_word  = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference behaviour: {num_of_errors, data_out} for one accepted word.
    function automatic logic [33:0] model(input logic [31:0] cw, input logic [5:0] sv,
                                          input logic ic, input logic [4:0] wc,
                                          input logic [1:0] enc);
        int          w;
        logic [31:0] d;
        w = enc[1] ? 32 : (enc[0] ? 16 : 8);
        d = (w == 32) ? cw : (cw & ((32'd1 << w) - 32'd1));
        if (sv == 6'd0) return {2'd0, d};
        if (ic && (int'(wc) < w)) return {2'd1, d ^ (32'd1 << wc)};
        return {2'd2, d};
    endfunction

    // Scoreboard: every output handshake must match the next expected word.
    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            if (prev_stall) begin
                chk("hold_valid", {63'd0, out_valid}, 64'd1);
                chk("hold_word", {30'd0, num_of_errors, data_out}, {30'd0, prev_word});
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_output: got %0h, expected no word", {num_of_errors, data_out});
                end else begin
                    chk("out_word", {30'd0, num_of_errors, data_out}, {30'd0, expq.pop_front()});
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = {num_of_errors, data_out};
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic send(input logic [31:0] cw, input logic [5:0] sv, input logic ic,
                        input logic [4:0] wc, input logic [1:0] enc);
        codeword       = cw;
        s              = sv;
        isCol          = ic;
        whatCol        = wc;
        codeword_width = enc;
        in_valid       = 1'b1;
        for (int k = 0; k < 100; k++) begin
            #1;
            if (in_ready) begin
                expq.push_back(model(cw, sv, ic, wc, enc));
                @(negedge clk);
                in_valid = 1'b0;
                return;
            end
            n_waits++;
            @(negedge clk);
        end
        n_total++;
        $display("FAIL accept_timeout: in_ready got 0, expected 1 within 100 cycles");
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            #3;
            if (expq.size() == 0 && !out_valid) begin
                @(negedge clk);
                return;
            end
        end
        n_total++;
        $display("FAIL drain_timeout: queue depth %0d, expected 0", expq.size());
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] pat;
        rst = 1'b0; in_valid = 1'b0; codeword = '0; s = '0; codeword_width = CW_32;
        isCol = 1'b0; whatCol = '0; out_ready = 1'b1; stats_clr = 1'b0;
        pat = 16'b1010_0110_1100_0101;

        repeat (3) @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_data_out", {32'd0, data_out}, 64'd0);
        chk("rst_num_err", {62'd0, num_of_errors}, 64'd0);
        chk("rst_single_cnt", {62'd0, single_cnt}, 64'd0);
        rst = 1'b1;
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk_en = 1'b1;
        @(negedge clk);

        chk("model_16b", {30'd0, model(32'hFFFF_1234, 6'b010011, 1'b1, 5'd5, CW_16)},
            {30'd0, 2'd1, 32'h0000_1214});
        chk("model_8b_multi", {30'd0, model(32'hDEAD_BEEF, 6'b000111, 1'b0, 5'd0, CW_8)},
            {30'd0, 2'd2, 32'h0000_00EF});
        chk("model_8b_col12", {30'd0, model(32'h0000_1F3C, 6'h15, 1'b1, 5'd12, CW_8)},
            {30'd0, 2'd2, 32'h0000_003C});

        // Latency: out_valid exactly two cycles after the accepting edge.
        send(32'hA5A5_A5A5, 6'd0, 1'b0, 5'd0, CW_32);
        #1;
        chk("lat_not_early", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        #1;
        chk("lat_valid", {63'd0, out_valid}, 64'd1);
        chk("lat_data", {32'd0, data_out}, {32'd0, 32'hA5A5_A5A5});
        chk("lat_num", {62'd0, num_of_errors}, 64'd0);
        drain();

        send(32'hFFFF_1234, 6'b010011, 1'b1, 5'd5, CW_16);
        @(negedge clk);
        #1;
        chk("w16_data", {32'd0, data_out}, {32'd0, 32'h0000_1214});
        chk("w16_num", {62'd0, num_of_errors}, 64'd1);
        drain();

        send(32'hDEAD_BEEF, 6'b000111, 1'b0, 5'd0, CW_8);
        @(negedge clk);
        #1;
        chk("w8_multi_data", {32'd0, data_out}, {32'd0, 32'h0000_00EF});
        chk("w8_multi_num", {62'd0, num_of_errors}, 64'd2);
        drain();

        send(32'h0000_1F3C, 6'h15, 1'b1, 5'd12, CW_8);
        @(negedge clk);
        #1;
        chk("w8_col12_data", {32'd0, data_out}, {32'd0, 32'h0000_003C});
        chk("w8_col12_num", {62'd0, num_of_errors}, 64'd2);
        drain();

        // Back-to-back mixed widths and boundary columns with out_ready held high.
        n_waits = 0;
        send(32'h0000_0000, 6'h21, 1'b1, 5'd31, CW_32);
        send(32'h1234_5678, 6'h0A, 1'b1, 5'd15, CW_16);
        send(32'h1234_5678, 6'h0A, 1'b1, 5'd16, CW_16);
        send(32'hCAFE_F00D, 6'h03, 1'b1, 5'd7,  CW_8);
        send(32'hCAFE_F00D, 6'h03, 1'b1, 5'd8,  CW_8);
        send(32'h8000_0001, 6'h00, 1'b1, 5'd3,  2'b11);
        send(32'h8000_0001, 6'h3F, 1'b1, 5'd0,  2'b11);
        send(32'h5555_AAAA, 6'h11, 1'b0, 5'd2,  CW_16);
        chk("stream_no_bubble", n_waits, 64'd0);
        drain();

        // Stall: two words fill the pipe, then in_ready must drop.
        fork
            begin
                send(32'h0000_0011, 6'h00, 1'b0, 5'd0, CW_32);
                send(32'h0000_2222, 6'h05, 1'b1, 5'd1, CW_16);
                send(32'h0000_0033, 6'h07, 1'b0, 5'd0, CW_8);
                send(32'h4444_4444, 6'h09, 1'b1, 5'd30, CW_32);
            end
            begin
                out_ready = 1'b0;
                @(negedge clk);
                @(negedge clk);
                #1;
                chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
                @(negedge clk);
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();

        // Irregular downstream readiness over a stream.
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    send(32'h0101_0101 * (i + 1), 6'(i), 1'b1, 5'(3 * i), 2'(i % 3));
                end
            end
            begin
                for (int i = 0; i < 24; i++) begin
                    out_ready = pat[i % 16];
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
        join
        drain();

`ifdef DEC_ERR_STATS_EN
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        #1;
        chk("clr_single", {62'd0, single_cnt}, 64'd0);
        chk("clr_double", {62'd0, double_cnt}, 64'd0);
        @(negedge clk);
        send(32'h0000_0001, 6'h01, 1'b1, 5'd0, CW_8);
        send(32'h0000_0002, 6'h02, 1'b1, 5'd1, CW_8);
        send(32'h0000_0004, 6'h03, 1'b0, 5'd2, CW_8);
        send(32'h0000_0008, 6'h04, 1'b1, 5'd3, CW_8);
        drain();
        chk("stats_single", {62'd0, single_cnt}, 64'd3);
        chk("stats_double", {62'd0, double_cnt}, 64'd1);
        send(32'h0000_0010, 6'h05, 1'b1, 5'd4, CW_8);
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        #1;
        chk("clr_prio_single", {62'd0, single_cnt}, 64'd0);
        chk("clr_prio_double", {62'd0, double_cnt}, 64'd0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            send(32'h0000_00F0, 6'h06, 1'b1, 5'(i), CW_8);
        end
        drain();
        chk("sat_single", {62'd0, single_cnt}, 64'd3);
`else
        chk("off_single", {62'd0, single_cnt}, 64'd0);
        chk("off_double", {62'd0, double_cnt}, 64'd0);
`endif

        // Reset mid-stream drops in-flight words.
        out_ready = 1'b0;
        send(32'h0000_AAAA, 6'h01, 1'b1, 5'd1, CW_16);
        send(32'h0000_BBBB, 6'h02, 1'b1, 5'd2, CW_16);
        chk_en = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_data", {32'd0, data_out}, 64'd0);
        chk("mid_rst_num", {62'd0, num_of_errors}, 64'd0);
        chk("mid_rst_single", {62'd0, single_cnt}, 64'd0);
        chk("mid_rst_double", {62'd0, double_cnt}, 64'd0);
        expq.delete();
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        send(32'h0000_0F0F, 6'h00, 1'b0, 5'd0, CW_16);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
